// File: rtl/simul_axi_pkg.sv
// Shared definitions for the simulation AXI3 read-slave model.
//   - burst / response encodings
//   - ar_cmd_t: the fixed-width part of a queued AR command (len/size/burst).
//     ID and address are packed alongside it by the top, because their
//     widths are per-instance parameters.
//   - is_slverr(): decides whether a whole burst is answered with SLVERR.
package simul_axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BURST
    } rd_state_t;

    typedef struct packed {
        logic [3:0] len;
        logic [2:0] size;
        burst_t     burst;
    } ar_cmd_t;

    // addr_lo only needs enough bits to test alignment for the largest size (128 B).
    function automatic logic is_slverr(input ar_cmd_t c, input logic [6:0] addr_lo,
                                       input int unsigned max_bytes);
        logic [7:0] bytes;
        logic [6:0] amask;
        logic       wrap_len_ok;
        bytes       = 8'd1 << c.size;
        amask       = 7'(bytes - 8'd1);
        wrap_len_ok = c.len inside {4'd1, 4'd3, 4'd7, 4'd15};
        is_slverr   = (c.burst == BURST_RSVD)
                   || (c.burst == BURST_WRAP && !wrap_len_ok)
                   || (c.burst == BURST_WRAP && (addr_lo & amask) != 7'd0)
                   || (32'(bytes) > max_bytes);
    endfunction

endpackage

// File: rtl/simul_axi_rd_cmd_queue.sv
// Synchronous FIFO holding accepted AR commands.
//   clk, reset   : clock, synchronous active-high reset
//   in_data/in_valid/in_ready : push side; in_ready is registered
//   out_data/out_valid/pop    : pop side; out_data is the current head
//   count        : number of stored entries
// DEPTH must be a power of two so the pointers wrap naturally.
module simul_axi_rd_cmd_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count_next;
    logic             push, do_pop;

    assign push      = in_valid && in_ready;
    assign out_valid = (count != '0);
    assign do_pop    = pop && out_valid;
    assign out_data  = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (push && !do_pop)
            count_next = count + (AW+1)'(1);
        else if (!push && do_pop)
            count_next = count - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_ready <= 1'b0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count    <= count_next;
            // Registered ready: low exactly when next cycle's occupancy is full.
            in_ready <= (count_next != FULL_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

endmodule

// File: rtl/simul_axi_slave_rdresp.sv
// Simulation AXI3 read slave: queues AR commands and answers each with an
// R burst whose data is the beat address (no memory behind it).
//   clk, reset                          : clock, synchronous active-high reset
//   arid/araddr/arlen/arsize/arburst,
//   arvalid/arready                     : AR channel (arready = queue not full)
//   rid/rdata/rresp/rlast/rvalid/rready : R channel
//   busy                                : queue non-empty or burst in progress
// Optional: define SIMUL_AXI_SLAVE_RD_STALL_EN to insert pseudo-random
// gaps before each beat, driven by an 8-bit Galois LFSR.
module simul_axi_slave_rdresp
    import simul_axi_pkg::*;
#(
    parameter int         ID_WIDTH      = 12,
    parameter int         ADDRESS_WIDTH = 32,
    parameter int         DATA_WIDTH    = 32,
    parameter int         DEPTH         = 8,
    parameter int         LATENCY       = 0,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ID_WIDTH-1:0]      arid,
    input  logic [ADDRESS_WIDTH-1:0] araddr,
    input  logic [3:0]               arlen,
    input  logic [2:0]               arsize,
    input  logic [1:0]               arburst,
    input  logic                     arvalid,
    output logic                     arready,
    output logic [ID_WIDTH-1:0]      rid,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic [1:0]               rresp,
    output logic                     rlast,
    output logic                     rvalid,
    input  logic                     rready,
    output logic                     busy
);
    localparam int QW = ID_WIDTH + ADDRESS_WIDTH + $bits(ar_cmd_t);
    localparam int unsigned DATA_BYTES = DATA_WIDTH / 8;
    localparam logic [15:0] WAIT_INIT = (LATENCY > 0) ? 16'(LATENCY - 1) : 16'd0;
    localparam rd_state_t   AFTER_POP = (LATENCY > 0) ? ST_WAIT : ST_BURST;

    rd_state_t state, state_next;

    ar_cmd_t                  in_cmd, head_cmd, cur_cmd;
    logic [QW-1:0]            q_in, q_out;
    logic                     q_valid, pop;
    logic [$clog2(DEPTH):0]   q_count;
    logic [ID_WIDTH-1:0]      head_id, cur_id;
    logic [ADDRESS_WIDTH-1:0] head_addr, cur_addr, next_addr, step, wrap_b, wrap_m;
    logic [3:0]               cur_beat;
    resp_t                    cur_resp;
    logic [15:0]              wcnt;
    logic                     shown, hs, last_beat, stall;

    assign in_cmd = '{len: arlen, size: arsize, burst: burst_t'(arburst)};
    assign q_in   = {arid, araddr, in_cmd};
    assign {head_id, head_addr, head_cmd} = q_out;

    simul_axi_rd_cmd_queue #(.WIDTH(QW), .DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .reset     (reset),
        .in_data   (q_in),
        .in_valid  (arvalid),
        .in_ready  (arready),
        .out_data  (q_out),
        .out_valid (q_valid),
        .pop       (pop),
        .count     (q_count)
    );

`ifdef SIMUL_AXI_SLAVE_RD_STALL_EN
    logic [7:0] lfsr;
    // Right-shifting Galois form of x^8+x^6+x^5+x^4+1.
    always_ff @(posedge clk) begin
        if (reset) lfsr <= LFSR_SEED;
        else       lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
    end
    assign stall = lfsr[0];
`else
    assign stall = 1'b0;
`endif

    assign hs        = rvalid && rready;
    assign last_beat = (cur_beat == cur_cmd.len);

    // Address of the following beat for the burst in flight.
    always_comb begin
        step      = ADDRESS_WIDTH'(1) << cur_cmd.size;
        wrap_b    = ADDRESS_WIDTH'({1'b0, cur_cmd.len} + 5'd1) << cur_cmd.size;
        wrap_m    = wrap_b - ADDRESS_WIDTH'(1);
        next_addr = cur_addr;
        case (cur_cmd.burst)
            BURST_INCR: next_addr = cur_addr + step;
            BURST_WRAP: next_addr = (cur_addr & ~wrap_m) | ((cur_addr + step) & wrap_m);
            default:    next_addr = cur_addr;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next state; pop is issued here so the last beat can chain straight
    // into the next burst on the same edge.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            ST_IDLE: if (q_valid) begin
                pop        = 1'b1;
                state_next = AFTER_POP;
            end
            ST_WAIT: if (wcnt == 16'd0) state_next = ST_BURST;
            ST_BURST: if (hs && last_beat) begin
                if (q_valid) begin
                    pop        = 1'b1;
                    state_next = AFTER_POP;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs. Once a beat is shown it stays valid regardless of the stall.
    always_comb begin
        rvalid = (state == ST_BURST) && (shown || !stall);
        rlast  = (state == ST_BURST) && last_beat;
        rid    = cur_id;
        rdata  = DATA_WIDTH'(cur_addr);
        rresp  = cur_resp;
        busy   = (q_count != '0) || (state != ST_IDLE);
    end

    // Burst datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_id   <= '0;
            cur_addr <= '0;
            cur_cmd  <= '0;
            cur_beat <= '0;
            cur_resp <= RESP_OKAY;
            wcnt     <= '0;
            shown    <= 1'b0;
        end else begin
            if (pop) begin
                cur_id   <= head_id;
                cur_addr <= head_addr;
                cur_cmd  <= head_cmd;
                cur_beat <= '0;
                cur_resp <= is_slverr(head_cmd, 7'(head_addr), DATA_BYTES) ? RESP_SLVERR : RESP_OKAY;
                wcnt     <= WAIT_INIT;
            end else if (hs) begin
                cur_addr <= next_addr;
                cur_beat <= cur_beat + 4'd1;
            end
            if (state == ST_WAIT) wcnt <= wcnt - 16'd1;
            shown <= rvalid && !rready;
        end
    end

endmodule
